// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types plus the pattern-history-table counter encoding.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  // 2-bit saturating branch counter; MSB is the taken prediction.
  typedef logic [1:0] pht_ctr_t;

  localparam pht_ctr_t PHT_WNT = 2'b01;  // weakly not-taken (post-init value)
  localparam pht_ctr_t PHT_WT  = 2'b10;  // weakly taken

  typedef enum logic {PHT_INIT, PHT_RUN} pht_state_t;

  // Saturating train step: +1 toward 2'b11 on taken, -1 toward 2'b00 otherwise.
  function automatic pht_ctr_t pht_ctr_next(input pht_ctr_t c, input logic taken);
    pht_ctr_t n;
    n = c;
    if (taken) begin
      if (c != 2'b11) n = c + 2'b01;
    end else begin
      if (c != 2'b00) n = c - 2'b01;
    end
    return n;
  endfunction

endpackage

// File: rtl/pht_idx_fifo.sv
// In-order FIFO of PHT indices for predictions awaiting resolution.
// Latency: push visible at head/count the cycle after; head is read combinationally.
// Backpressure: push ignored when full, pop ignored when empty; flush empties it and wins over push/pop.
// Ports: clk/rst_n; push + push_idx; pop; flush; head_idx (oldest entry); empty, full, count.
module pht_idx_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_idx,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  head_idx,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign head_idx = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_idx;
  end

endmodule

// File: rtl/gshare_pht.sv
// Gshare/bimodal branch predictor: PHT of 2-bit counters, lookup at fetch, train at resolve.
// Latency: prediction registered, 1 cycle after lookup; training visible to lookups the next cycle.
// Backpressure: ready=0 during the init sweep or while the in-flight queue is full; lookups are then dropped.
// Ports: clk, rst_n (async active-low); bhr_in, fetch_valid/fetch_is_br/fetch_pc (lookup);
//   ready, predict_valid/predict_taken (prediction); resolve_valid/resolve_taken (training);
//   flush (drop in-flight entries); q_count (in-flight entries).
// Build option: define GSHARE_PHT_XOR_EN to hash bhr_in into the index (gshare); otherwise bimodal.
module gshare_pht
  import lc3b_types::*;
#(
  parameter int HIST_W  = 4,
  parameter int IDX_W   = 4,
  parameter int Q_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [HIST_W-1:0]          bhr_in,
  input  logic                       fetch_valid,
  input  logic                       fetch_is_br,
  input  lc3b_word                   fetch_pc,
  output logic                       ready,
  output logic                       predict_valid,
  output logic                       predict_taken,
  input  logic                       resolve_valid,
  input  logic                       resolve_taken,
  input  logic                       flush,
  output logic [$clog2(Q_DEPTH):0]   q_count
);

  localparam int ENTRIES = 1 << IDX_W;

  pht_state_t       state;
  pht_state_t       state_nxt;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_nxt;

  pht_ctr_t         pht [ENTRIES];

  logic             run;
  logic             lookup;
  logic             resolve;
  logic             q_empty;
  logic             q_full;
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] head_idx;

  // Only PC bits [IDX_W:1] feed the index; the rest are intentionally ignored.
  logic             unused_pc;
  assign unused_pc = ^{fetch_pc[15:IDX_W+1], fetch_pc[0]};

`ifdef GSHARE_PHT_XOR_EN
  assign fetch_idx = fetch_pc[IDX_W:1] ^ IDX_W'(bhr_in);
`else
  logic unused_bhr;
  assign unused_bhr = ^bhr_in;
  assign fetch_idx  = fetch_pc[IDX_W:1];
`endif

  // Init sweep: one entry per cycle, then run until the next reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PHT_INIT;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      PHT_INIT: begin
        ptr_nxt = ptr + IDX_W'(1);
        if (ptr == IDX_W'(ENTRIES - 1)) state_nxt = PHT_RUN;
      end
      PHT_RUN: begin
        ptr_nxt = ptr;
      end
      default: begin
        state_nxt = PHT_INIT;
        ptr_nxt   = '0;
      end
    endcase
  end

  assign run     = (state == PHT_RUN);
  assign ready   = run && !q_full;
  assign lookup  = fetch_valid && fetch_is_br && ready;
  // A same-cycle push cannot satisfy a resolve on an empty queue.
  assign resolve = run && resolve_valid && !q_empty;

  // Counter array: swept to weakly not-taken in INIT, trained at the queue head in RUN.
  // The lookup below samples the old value, giving read-before-write on collisions.
  always_ff @(posedge clk) begin
    if (!run) begin
      pht[ptr] <= PHT_WNT;
    end else if (resolve) begin
      pht[head_idx] <= pht_ctr_next(pht[head_idx], resolve_taken);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      predict_valid <= 1'b0;
      predict_taken <= 1'b0;
    end else begin
      predict_valid <= lookup;
      predict_taken <= lookup && pht[fetch_idx][1];
    end
  end

  // Flush still lets a same-cycle lookup predict, but its index is not queued.
  pht_idx_fifo #(
    .W     (IDX_W),
    .DEPTH (Q_DEPTH),
    .CW    ($clog2(Q_DEPTH) + 1)
  ) u_idx_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (lookup && !flush),
    .push_idx (fetch_idx),
    .pop      (resolve),
    .flush    (flush),
    .head_idx (head_idx),
    .empty    (q_empty),
    .full     (q_full),
    .count    (q_count)
  );

endmodule

// File: tb/tb_gshare_pht.sv
// Directed bench for gshare_pht with a prediction scoreboard.
// Latency: expected predictions are queued at issue and popped when predict_valid is seen.
// Backpressure: drives lookups past a full queue and checks they are dropped.
module tb_gshare_pht;

  localparam int HIST_W  = 4;
  localparam int IDX_W   = 4;
  localparam int Q_DEPTH = 4;
  localparam int CW      = $clog2(Q_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [HIST_W-1:0] bhr_in = '0;
  logic              fetch_valid = 1'b0;
  logic              fetch_is_br = 1'b0;
  logic [15:0]       fetch_pc = '0;
  logic              ready;
  logic              predict_valid;
  logic              predict_taken;
  logic              resolve_valid = 1'b0;
  logic              resolve_taken = 1'b0;
  logic              flush = 1'b0;
  logic [CW-1:0]     q_count;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  gshare_pht #(
    .HIST_W  (HIST_W),
    .IDX_W   (IDX_W),
    .Q_DEPTH (Q_DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bhr_in        (bhr_in),
    .fetch_valid   (fetch_valid),
    .fetch_is_br   (fetch_is_br),
    .fetch_pc      (fetch_pc),
    .ready         (ready),
    .predict_valid (predict_valid),
    .predict_taken (predict_taken),
    .resolve_valid (resolve_valid),
    .resolve_taken (resolve_taken),
    .flush         (flush),
    .q_count       (q_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every emitted prediction must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && predict_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_predict: got valid taken=%0b expected no prediction", predict_taken);
      end else begin
        bit e;
        e = exp_q.pop_front();
        if (predict_taken !== e) begin
          errors++;
          $display("FAIL predict_taken: got %0b expected %0b", predict_taken, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [15:0] pc, input logic [3:0] bhr, input bit exp);
    fetch_valid = 1'b1;
    fetch_is_br = 1'b1;
    fetch_pc    = pc;
    bhr_in      = bhr;
    exp_q.push_back(exp);
    tick();
    fetch_valid = 1'b0;
    fetch_is_br = 1'b0;
  endtask

  task automatic resolve(input bit t);
    resolve_valid = 1'b1;
    resolve_taken = t;
    tick();
    resolve_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic sweep_check(input string tag);
    for (int i = 0; i < 15; i++) tick();
    check({tag, "_ready_before_end"}, 32'(ready), 0);
    tick();
    check({tag, "_ready_after_sweep"}, 32'(ready), 1);
  endtask

  initial begin
    bit nt_exp[5];
    nt_exp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset state
    #12;
    check("rst_ready", 32'(ready), 0);
    check("rst_q_count", 32'(q_count), 0);
    check("rst_predict_valid", 32'(predict_valid), 0);
    check("rst_predict_taken", 32'(predict_taken), 0);
    tick();
    rst_n = 1'b1;
    sweep_check("init");

    // 16 distinct indices, all weakly not-taken; flush keeps the queue empty
    for (int i = 0; i < 16; i++) begin
      fetch_valid = 1'b1;
      fetch_is_br = 1'b1;
      flush       = 1'b1;
      fetch_pc    = 16'(i << 1);
      bhr_in      = '0;
      exp_q.push_back(1'b0);
      tick();
    end
    fetch_valid = 1'b0;
    fetch_is_br = 1'b0;
    flush       = 1'b0;
    check("flush_lookup_q_count", 32'(q_count), 0);

    // Train idx 8 up to 11, then down to 00 and hold
    lookup(16'h0010, 4'b0000, 1'b0);
    resolve(1'b1);
    lookup(16'h0010, 4'b0000, 1'b1);
    resolve(1'b1);
    for (int k = 0; k < 5; k++) begin
      lookup(16'h0010, 4'b0000, nt_exp[k]);
      resolve(1'b0);
    end
    lookup(16'h0010, 4'b0000, 1'b0);
    resolve(1'b0);
    check("train_q_count", 32'(q_count), 0);

    // History hashing: idx 8 trained to 10, idx 0 untouched at 01
    lookup(16'h0010, 4'b0000, 1'b0);
    resolve(1'b1);
    lookup(16'h0010, 4'b0000, 1'b0);
    resolve(1'b1);
    lookup(16'h0010, 4'b0000, 1'b1);
`ifdef GSHARE_PHT_XOR_EN
    lookup(16'h0010, 4'b1000, 1'b0);
`else
    lookup(16'h0010, 4'b1000, 1'b1);
`endif
    lookup(16'h0000, 4'b0000, 1'b0);
    check("hash_q_count", 32'(q_count), 3);
    do_flush();

    // Fill the queue, attempt a fifth lookup, then drain one
    lookup(16'h0002, 4'b0000, 1'b0);
    lookup(16'h0004, 4'b0000, 1'b0);
    lookup(16'h0006, 4'b0000, 1'b0);
    lookup(16'h000C, 4'b0000, 1'b0);
    check("full_q_count", 32'(q_count), 4);
    check("full_ready", 32'(ready), 0);
    fetch_valid = 1'b1;
    fetch_is_br = 1'b1;
    fetch_pc    = 16'h0008;
    tick();
    fetch_valid = 1'b0;
    fetch_is_br = 1'b0;
    @(negedge clk);
    check("full_no_predict", 32'(predict_valid), 0);
    check("full_no_push", 32'(q_count), 4);
    @(posedge clk);
    #1;
    resolve(1'b1);
    check("drain_q_count", 32'(q_count), 3);
    check("drain_ready", 32'(ready), 1);

    // Flush with a simultaneous resolve: head (idx 2) still trained
    resolve_valid = 1'b1;
    resolve_taken = 1'b1;
    flush         = 1'b1;
    tick();
    resolve_valid = 1'b0;
    flush         = 1'b0;
    check("flush_resolve_q_count", 32'(q_count), 0);
    lookup(16'h0004, 4'b0000, 1'b1);
    lookup(16'h0002, 4'b0000, 1'b1);
    do_flush();

    // Same-cycle lookup and resolve on idx 5 at 01: old value read, new visible next
    lookup(16'h000A, 4'b0000, 1'b0);
    fetch_valid   = 1'b1;
    fetch_is_br   = 1'b1;
    fetch_pc      = 16'h000A;
    resolve_valid = 1'b1;
    resolve_taken = 1'b1;
    exp_q.push_back(1'b0);
    tick();
    fetch_valid   = 1'b0;
    fetch_is_br   = 1'b0;
    resolve_valid = 1'b0;
    check("pushpop_q_count", 32'(q_count), 1);
    lookup(16'h000A, 4'b0000, 1'b1);
    do_flush();

    // Resolve on empty queue is ignored, even with a same-cycle push
    resolve(1'b1);
    check("empty_resolve_q_count", 32'(q_count), 0);
    fetch_valid   = 1'b1;
    fetch_is_br   = 1'b1;
    fetch_pc      = 16'h000E;
    resolve_valid = 1'b1;
    resolve_taken = 1'b1;
    exp_q.push_back(1'b0);
    tick();
    fetch_valid   = 1'b0;
    fetch_is_br   = 1'b0;
    resolve_valid = 1'b0;
    check("empty_push_resolve_q_count", 32'(q_count), 1);
    do_flush();

    // Asynchronous reset with entries queued and a prediction pending
    lookup(16'h0014, 4'b0000, 1'b0);
    lookup(16'h0014, 4'b0000, 1'b0);
    fetch_valid = 1'b1;
    fetch_is_br = 1'b1;
    fetch_pc    = 16'h0014;
    tick();
    fetch_valid = 1'b0;
    fetch_is_br = 1'b0;
    check("prereset_q_count", 32'(q_count), 3);
    rst_n = 1'b0;
    #1;
    check("async_rst_predict_valid", 32'(predict_valid), 0);
    check("async_rst_q_count", 32'(q_count), 0);
    check("async_rst_ready", 32'(ready), 0);
    tick();
    rst_n = 1'b1;

    // Reset mid-sweep: the full sweep restarts from entry 0
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    #1;
    check("midsweep_rst_ready", 32'(ready), 0);
    tick();
    rst_n = 1'b1;
    sweep_check("resweep");
    lookup(16'h0010, 4'b0000, 1'b0);
    lookup(16'h0004, 4'b0000, 1'b0);
    do_flush();

    for (int i = 0; i < 3; i++) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gshare_pht.md
# gshare_pht

Pattern history table and branch predictor that consumes the 4-bit global branch history produced by the pipeline's history register. At fetch, a conditional branch's word-aligned PC is hashed with the history to select a 2-bit saturating counter, and a registered taken/not-taken prediction is returned. Each lookup's index is queued in order. When the branch resolves in the execute stage, the queued index is popped and its counter is trained.

## Interface
- HIST_W, 4, width of `bhr_in`; must be ≤ IDX_W
- IDX_W, 4, table index width; table holds 2^IDX_W counters
- Q_DEPTH, 4, in-flight prediction queue depth; power of two
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- bhr_in  in  HIST_W  current global history
- fetch_valid  in  1  fetch stage holds a valid instruction
- fetch_is_br  in  1  instruction is `op_br` with any nzp bit set (decoded upstream)
- fetch_pc  in  16  `lc3b_word` fetch address
- ready  out  1  init sweep done and queue not full
- predict_valid  out  1  `predict_taken` is meaningful this cycle
- predict_taken  out  1  counter MSB of the looked-up entry
- resolve_valid  in  1  oldest in-flight branch resolved this cycle
- resolve_taken  in  1  actual outcome
- flush  in  1  discard all in-flight entries
- q_count  out  $clog2(Q_DEPTH)+1  in-flight entries

## Operation
- FSM states are INIT and RUN. Reset forces INIT with sweep pointer 0, queue empty, and all outputs 0.
- INIT writes 2'b01 (weakly not-taken) to entry[ptr] and increments ptr each cycle. After entry 2^IDX_W−1 the FSM goes to RUN. `ready`=0 throughout INIT; fetch and resolve inputs are ignored.
- Index: idx = fetch_pc[IDX_W:1] XOR {zero-extend(bhr_in)}. Bit 0 is dropped because fetch is word-aligned.
- Lookup occurs when RUN && fetch_valid && fetch_is_br && ready. It reads entry[idx] and pushes idx onto the queue.
- Lookup with `ready`=0 is a protocol violation. There is no push, and `predict_valid` stays 0.
- Resolve occurs when RUN && resolve_valid && queue non-empty. It pops the head index and updates the counter at that index:
  - If taken, the counter saturates at 2'b11 (+1).
  - If not taken, the counter saturates at 2'b00 (−1).
- Resolve on an empty queue is ignored.
- Push and pop in the same cycle: `q_count` is unchanged.
- On an empty queue, a same-cycle push does not satisfy the pop; the resolve is ignored.
- Same-cycle lookup and update at the same index: the lookup returns the pre-update value (read before write).
- Flush with resolve in the same cycle: the resolve's update is applied first, then the queue is emptied. A same-cycle lookup is not pushed, and its prediction is still emitted.
- Flush does not touch the PHT.
- `rst_n` low at any time, including mid-sweep or with entries queued, returns the block to INIT asynchronously.

## Timing
- Prediction latency is 1 cycle. `predict_valid` and `predict_taken` are registered and valid the cycle after the lookup. Both are 0 otherwise.
- A counter update is visible to lookups starting the cycle after the resolve.
- `ready` and `q_count` are registered and reflect state after the current edge.
- The init sweep takes exactly 2^IDX_W cycles after `rst_n` deasserts. `ready` rises on cycle 2^IDX_W+1 unless the queue is full.

## Configuration
- `GSHARE_PHT_XOR_EN` defined: the index hashes in history as above (gshare).
- Macro undefined: idx = fetch_pc[IDX_W:1] (bimodal). `bhr_in` is unused, and everything else is identical.

## Structure
- Add the following to `lc3b_types`:
  - `pht_ctr_t` (logic [1:0])
  - constants `PHT_WNT`=2'b01 and `PHT_WT`=2'b10
  - enum `pht_state_t` {PHT_INIT, PHT_RUN}
- One sub-module, `pht_idx_fifo`: a synchronous in-order FIFO of IDX_W-bit indices with push/pop/flush/count. The predictor instantiates it once.

## Test plan
- Reset, then 16 idle cycles: `ready` rises after exactly 16 cycles, and 16 lookups of distinct indices all give `predict_taken`=0.
- PC 0x0010, bhr 4'b0000, resolved taken twice: the third lookup gives `predict_taken`=1. Four not-taken resolves bring the counter to 00, and a fifth stays at 00.
- With the macro defined, PC 0x0010 with bhr 4'b1000 vs 4'b0000 selects idx 0 vs 8. Training idx 8 taken ×2 does not change the prediction for idx 0.
- Four lookups without resolve: `q_count`=4 and `ready`=0. A fifth fetch_is_br gives no push and `predict_valid`=0. One resolve brings `q_count` to 3 and `ready` back to 1.
- Lookup and resolve to the same index in the same cycle, counter at 01, taken: `predict_taken`=0 that cycle, and the next lookup returns 1.
- Flush with 3 queued and a simultaneous resolve: the head counter is updated and `q_count`=0. Assert `rst_n` low mid-sweep: outputs drop to 0 immediately and the sweep restarts at 0.
